// File: rtl/seg_mux_driver.sv
// Multiplexed hex driver for NUM_DIGITS common-anode 7-seg digits, guard-banded scan, frame-atomic double buffer.
// Latency: outputs registered one cycle behind scan state; load becomes visible at the next wrap plus one cycle.
// Backpressure: none; load is a fire-and-forget strobe, last load per frame wins. Option: SEG_LEADING_ZERO_BLANK_EN.
module seg_mux_driver #(
  parameter int NUM_DIGITS     = 2,
  parameter int REFRESH_DIV    = 24000,
  parameter int GUARD_CYCLES   = 48,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1,
  localparam int IW            = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [IW-1:0]           digit_idx,
  output logic                    frame_done
);

  localparam int CNT_MAX = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

  typedef enum logic {SHOW, GUARD} state_t;

  state_t                  r_state;
  logic                    r_run;
  logic                    r_pend;
  logic                    r_wrap;
  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_sh_digits;
  logic [4*NUM_DIGITS-1:0] r_act_digits;
  logic [NUM_DIGITS-1:0]   r_sh_blank;
  logic [NUM_DIGITS-1:0]   r_act_blank;

  logic                    w_last;
  logic [IW-1:0]           w_next_idx;
  logic                    w_cnt_zero;
  logic                    w_advance;
  logic                    w_wrap;
  logic [3:0]              w_nib;
  logic                    w_blank;
  logic [NUM_DIGITS-1:0]   w_an_onehot;
  logic [6:0]              w_seg_lit;
  logic [NUM_DIGITS-1:0]   w_an_lit;
`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic                    w_zero_above;
`endif

  // Active-high segment pattern, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'b0111111;
      4'h1: hex_glyph = 7'b0000110;
      4'h2: hex_glyph = 7'b1011011;
      4'h3: hex_glyph = 7'b1001111;
      4'h4: hex_glyph = 7'b1100110;
      4'h5: hex_glyph = 7'b1101101;
      4'h6: hex_glyph = 7'b1111101;
      4'h7: hex_glyph = 7'b0000111;
      4'h8: hex_glyph = 7'b1111111;
      4'h9: hex_glyph = 7'b1101111;
      4'hA: hex_glyph = 7'b1110111;
      4'hB: hex_glyph = 7'b1111100;
      4'hC: hex_glyph = 7'b0111001;
      4'hD: hex_glyph = 7'b1011110;
      4'hE: hex_glyph = 7'b1111001;
      default: hex_glyph = 7'b1110001;
    endcase
  endfunction

  assign w_last     = (r_idx == IW'(NUM_DIGITS - 1));
  assign w_next_idx = w_last ? '0 : r_idx + 1'b1;
  assign w_cnt_zero = (r_cnt == '0);
  assign w_advance  = r_run && w_cnt_zero && ((r_state == GUARD) || (GUARD_CYCLES == 0));
  assign w_wrap     = w_advance && w_last;

  always_comb begin
    w_nib       = 4'h0;
    w_blank     = 1'b0;
    w_an_onehot = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IW'(k)) begin
        w_nib          = r_act_digits[4*k +: 4];
        w_blank        = r_act_blank[k];
        w_an_onehot[k] = 1'b1;
      end
    end
`ifdef SEG_LEADING_ZERO_BLANK_EN
    // Walk down from the top digit; digit 0 is never suppressed.
    w_zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      w_zero_above = w_zero_above && (r_act_digits[4*k +: 4] == 4'h0);
      if ((r_idx == IW'(k)) && w_zero_above) w_blank = 1'b1;
    end
`endif
  end

  assign w_seg_lit = w_blank ? SEG_OFF : (hex_glyph(w_nib) ^ SEG_OFF);
  assign w_an_lit  = w_an_onehot ^ AN_OFF;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= SHOW;
      r_run        <= 1'b0;
      r_pend       <= 1'b0;
      r_wrap       <= 1'b0;
      r_cnt        <= CW'(REFRESH_DIV - 1);
      r_idx        <= '0;
      r_sh_digits  <= '0;
      r_act_digits <= '0;
      r_sh_blank   <= '1;
      r_act_blank  <= '1;
      seg          <= SEG_OFF;
      anode        <= AN_OFF;
      digit_idx    <= '0;
      frame_done   <= 1'b0;
    end else begin
      // The first cycle out of reset only arms the scan, so digit 0 lights one edge later.
      r_run  <= 1'b1;
      r_wrap <= w_wrap;

      if (load) begin
        r_sh_digits <= digits_in;
        r_sh_blank  <= blank_in;
      end
      if (w_wrap) begin
        if (load) begin
          r_act_digits <= digits_in;
          r_act_blank  <= blank_in;
        end else if (r_pend) begin
          r_act_digits <= r_sh_digits;
          r_act_blank  <= r_sh_blank;
        end
        r_pend <= 1'b0;
      end else if (load) begin
        r_pend <= 1'b1;
      end

      if (r_run) begin
        if (!w_cnt_zero) begin
          r_cnt <= r_cnt - 1'b1;
        end else if ((r_state == SHOW) && (GUARD_CYCLES != 0)) begin
          r_state <= GUARD;
          r_cnt   <= CW'(GUARD_CYCLES - 1);
        end else begin
          r_state <= SHOW;
          r_cnt   <= CW'(REFRESH_DIV - 1);
          r_idx   <= w_next_idx;
        end
      end

      if (!r_run || (r_state == GUARD)) begin
        seg       <= SEG_OFF;
        anode     <= AN_OFF;
        digit_idx <= (r_state == GUARD) ? w_next_idx : r_idx;
      end else begin
        seg       <= w_seg_lit;
        anode     <= w_an_lit;
        digit_idx <= r_idx;
      end
      frame_done <= r_wrap;
    end
  end

endmodule

// File: tb/tb_seg_mux_driver.sv
// Bench for seg_mux_driver: time-position reference model checked every cycle, plus literal glyph/anode pins.
module tb_seg_mux_driver;
  localparam int N = 2;
  localparam int R = 4;
  localparam int G = 1;
  localparam int P = R + G;
  localparam int F = N * P;

  logic       clk = 1'b0;
  logic       reset, load;
  logic [7:0] digits_in;
  logic [1:0] blank_in;
  logic [6:0] seg;
  logic [1:0] anode;
  logic [0:0] digit_idx;
  logic       frame_done;

  seg_mux_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .GUARD_CYCLES(G),
                   .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .load(load), .digits_in(digits_in), .blank_in(blank_in),
    .seg(seg), .anode(anode), .digit_idx(digit_idx), .frame_done(frame_done));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  string glyph_segs [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                             "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] glyph_low(input logic [3:0] n);
    string s;
    logic [6:0] v;
    s = glyph_segs[n];
    v = 7'h7F;
    for (int i = 0; i < s.len(); i++) v[int'(s[i]) - 97] = 1'b0;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outputs derived from edge count since reset and the frame geometry.
  int         e = 0;
  bit         chk_en = 1'b0;
  bit         watch_one = 1'b0;
  logic [7:0] m_act_d, m_sh_d;
  logic [1:0] m_act_b, m_sh_b;
  bit         m_pend;
  logic [6:0] exp_seg;
  logic [1:0] exp_an;
  logic [0:0] exp_idx;
  logic       exp_fd;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        e = 0; chk_en = 1'b1;
        m_act_d = 8'h00; m_sh_d = 8'h00; m_act_b = 2'b11; m_sh_b = 2'b11; m_pend = 1'b0;
        exp_seg = 7'h7F; exp_an = 2'b11; exp_idx = 1'b0; exp_fd = 1'b0;
      end else begin
        e++;
        if (e == 1) begin
          exp_seg = 7'h7F; exp_an = 2'b11; exp_idx = 1'b0; exp_fd = 1'b0;
        end else begin
          int p, pos, d, w;
          bit dark, zero_hi;
          p = e - 2; pos = p % F; d = pos / P; w = pos % P;
          exp_fd = (pos == 0) && (p >= F);
          if (w < R) begin
            dark = m_act_b[d];
            zero_hi = 1'b1;
            for (int k = d; k < N; k++) if (m_act_d[4*k +: 4] != 4'h0) zero_hi = 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
            if (d > 0 && zero_hi) dark = 1'b1;
`endif
            exp_seg = dark ? 7'h7F : glyph_low(m_act_d[4*d +: 4]);
            exp_an = 2'b11; exp_an[d] = 1'b0;
            exp_idx = 1'(d);
          end else begin
            exp_seg = 7'h7F; exp_an = 2'b11; exp_idx = 1'((d + 1) % N);
          end
        end
        if ((e - 1) >= F && ((e - 1) % F) == 0) begin
          if (load) begin m_act_d = digits_in; m_act_b = blank_in; end
          else if (m_pend) begin m_act_d = m_sh_d; m_act_b = m_sh_b; end
          m_pend = 1'b0;
        end else if (load) begin
          m_pend = 1'b1;
        end
        if (load) begin m_sh_d = digits_in; m_sh_b = blank_in; end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("seg", 32'(seg), 32'(exp_seg));
        check("anode", 32'(anode), 32'(exp_an));
        check("digit_idx", 32'(digit_idx), 32'(exp_idx));
        check("frame_done", 32'(frame_done), 32'(exp_fd));
        if (watch_one) begin
          n_tests++;
          if (seg == glyph_low(4'h1)) begin
            n_fail++;
            $display("FAIL no_stale_load: got seg %b, glyph 1 must never appear", seg);
          end
        end
      end
    end
  end

  task automatic wait_fd();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3 * F && !seen; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) seen = 1'b1;
    end
    check("frame_done_timeout", 32'(seen), 32'd1);
  endtask

  task automatic pin_frame(input string name, input logic [6:0] s0, input logic [6:0] s1);
    logic [6:0] g0, g1;
    g0 = 7'bx; g1 = 7'bx;
    repeat (F + 2) begin
      @(negedge clk);
      if (anode === 2'b10) g0 = seg;
      if (anode === 2'b01) g1 = seg;
    end
    check({name, "_d0"}, 32'(g0), 32'(s0));
    check({name, "_d1"}, 32'(g1), 32'(s1));
  endtask

  task automatic pulse_load(input logic [7:0] d, input logic [1:0] b);
    load = 1'b1; digits_in = d; blank_in = b;
    @(negedge clk);
    load = 1'b0;
  endtask

  logic [1:0] an_pat [12] = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11,
                              2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b10};

  initial begin
    reset = 1'b1; load = 1'b0; digits_in = 8'h00; blank_in = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_anode", 32'(anode), 32'h3);
    check("rst_idx", 32'(digit_idx), 32'h0);
    check("rst_fd", 32'(frame_done), 32'h0);
    reset = 1'b0;

    // First frame: literal anode sequence and wrap pulse, blank glyphs.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("first_frame_anode%0d", i + 1), 32'(anode), 32'(an_pat[i]));
      check($sformatf("first_frame_seg%0d", i + 1), 32'(seg), 32'h7F);
    end
    check("first_wrap_fd", 32'(frame_done), 32'h1);
    repeat (5) @(negedge clk);

    // Mid-frame load only shows after the wrap.
    pulse_load(8'h3A, 2'b00);
    check("load_hidden", 32'(seg), 32'h7F);
    wait_fd();
    pin_frame("load_3A", 7'b0001000, 7'b0110000);

    // Two loads in one frame: last wins, first never displayed.
    wait_fd();
    watch_one = 1'b1;
    @(negedge clk);
    pulse_load(8'h11, 2'b00);
    @(negedge clk);
    pulse_load(8'h22, 2'b00);
    wait_fd();
    pin_frame("last_wins_22", 7'b0100100, 7'b0100100);
    watch_one = 1'b0;

    // Load coincident with the wrap edge is applied at that wrap.
    wait_fd();
    repeat (8) @(negedge clk);
    pulse_load(8'h7F, 2'b00);
    @(negedge clk);
    check("wrap_load_fd", 32'(frame_done), 32'h1);
    check("wrap_load_seg", 32'(seg), 32'(7'b0001110));
    pin_frame("wrap_load_7F", 7'b0001110, 7'b1111000);

    // Reset during digit 1 drops the pending load.
    wait_fd();
    @(negedge clk);
    pulse_load(8'h55, 2'b00);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 2 * F && !seen; i++) begin
        @(negedge clk);
        if (anode === 2'b01) seen = 1'b1;
      end
      check("reach_digit1", 32'(seen), 32'd1);
    end
    reset = 1'b1;
    @(negedge clk);
    check("midreset_anode", 32'(anode), 32'h3);
    check("midreset_seg", 32'(seg), 32'h7F);
    check("midreset_idx", 32'(digit_idx), 32'h0);
    reset = 1'b0;
    pin_frame("pending_dropped", 7'h7F, 7'h7F);

    // Randomized traffic, occasional resets.
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      load = ($urandom_range(0, 6) == 0);
      digits_in = 8'($urandom);
      blank_in = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      reset = ($urandom_range(0, 249) == 0);
    end
    @(negedge clk);
    load = 1'b0; reset = 1'b0;

    // Leading-zero digit behaviour.
    pulse_load(8'h05, 2'b00);
    wait_fd();
`ifdef SEG_LEADING_ZERO_BLANK_EN
    pin_frame("lead_zero_05", 7'b0010010, 7'h7F);
`else
    pin_frame("lead_zero_05", 7'b0010010, 7'b1000000);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seg_mux_driver.md
# seg_mux_driver

Time-multiplexed hex driver for a bank of NUM_DIGITS common-anode seven-segment digits. It replaces the single-digit hex decoder with a multi-digit driver. Each digit owns a 4-bit nibble. The block scans one digit at a time, inserts a dark guard interval between digits to prevent ghosting, and double-buffers the digit values so an update never tears mid-frame. It sits between the datapath's value registers and the FPGA pins that drive the segment and anode transistors.

## Interface
- NUM_DIGITS, 2: digits scanned; ≥1.
- REFRESH_DIV, 24000: clk cycles each digit is lit; ≥1.
- GUARD_CYCLES, 48: all-anodes-off cycles after each digit; ≥0. With 0 the GUARD state is never entered.
- SEG_ACTIVE_LOW, 1: 1 means a lit segment drives 0.
- AN_ACTIVE_LOW, 1: 1 means the enabled anode drives 0.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- load  in  1  one-cycle strobe that captures digits_in and blank_in into the shadow registers.
- digits_in  in  4*NUM_DIGITS  nibble k = digit k; digit 0 is least significant.
- blank_in  in  NUM_DIGITS  bit k=1 forces digit k dark.
- seg  out  7  {g,f,e,d,c,b,a}, registered.
- anode  out  NUM_DIGITS  one-hot (polarity per AN_ACTIVE_LOW) or all-off, registered.
- digit_idx  out  $clog2(NUM_DIGITS) (min 1)  index currently lit or next to light, registered.
- frame_done  out  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to 0.

## Operation
- Registers:
  - Shadow pair (sh_digits, sh_blank) and pending flag, written on load.
  - Active pair (act_digits, act_blank), which is what gets displayed.
  - Down-counter, sized to max(REFRESH_DIV, GUARD_CYCLES).
  - State, one of SHOW or GUARD.
  - Digit index.
- SHOW: digit_idx lit.
  - Counter counts REFRESH_DIV-1 down to 0.
  - At 0: go to GUARD, loading GUARD_CYCLES-1; or, if GUARD_CYCLES=0, advance directly.
- GUARD: all anodes off, seg all off. At 0, advance.
- Advance:
  - idx = (idx == NUM_DIGITS-1) ? 0 : idx+1.
  - On wrap, pulse frame_done.
  - On wrap, if pending is set, copy shadow to active and clear pending.
  - Then enter SHOW with counter REFRESH_DIV-1.
- Buffering rules:
  - Active values change only at a wrap.
  - Multiple loads within a frame: the last one wins.
  - A load in the same cycle as a wrap is applied at that wrap.
- Decode: standard hex glyphs 0–9, A, b, C, d, E, F.
  - Example, active-low: 0 → 1000000, 8 → 0000000, F → 0001110.
  - A digit whose act_blank bit is set drives seg all-off while its anode is still enabled.
  - SEG_ACTIVE_LOW=0 inverts seg; AN_ACTIVE_LOW=0 inverts anode.
- NUM_DIGITS=1: idx stays 0 and every advance is a wrap.
- Reset values:
  - State SHOW, idx 0, counter REFRESH_DIV-1, pending 0.
  - act_digits 0, act_blank all 1s, shadow the same.
  - seg all-off, anode all-off, digit_idx 0, frame_done 0.

## Timing
- seg, anode, digit_idx and frame_done are registered: each reflects the state and counter one cycle later.
- First frame after reset deasserts:
  - anode[0] enables on the 2nd rising edge and stays on for REFRESH_DIV cycles.
  - Then GUARD_CYCLES dark cycles, then anode[1].
- Per-digit period is REFRESH_DIV+GUARD_CYCLES; frame period is NUM_DIGITS × that.
- frame_done is high for exactly one cycle, coincident with the first cycle of digit 0's anode.
- load to visible change: until the next wrap plus 1 cycle; at most one frame plus 1 cycle.
- reset asserted mid-frame: all outputs take their reset values on that edge, and any pending shadow data is discarded.

## Configuration
- SEG_LEADING_ZERO_BLANK_EN defined: digit k>0 is also blanked when act_digits[k] and every higher digit are 0. Digit 0 is never suppressed by this rule.
  - Example: 4 digits holding 0x0050 display as "  50".
- Undefined: all digits show their glyph, e.g. "0050". Only blank_in darkens digits.

## Test plan
- Test parameters: NUM_DIGITS=2, REFRESH_DIV=4, GUARD_CYCLES=1, both polarities active-low.
- Reset, then no load → seg=1111111 throughout; anode cycles 10 ×4 cycles, 11 ×1, 01 ×4, 11 ×1; frame_done pulses every 10 cycles.
- load with digits_in=0x3A, blank_in=00 mid-frame → nothing changes until the wrap; from the next frame, digit0 seg=0001000 (A) and digit1 seg=0110000 (3).
- Two loads in one frame, 0x11 then 0x22 → the next frame shows "22" only; 0x11 never appears.
- load coincident with the wrap cycle, 0x7F → "7F" appears in the frame starting at that wrap.
- reset asserted during digit1 SHOW → the next edge gives anode=11, seg=1111111, digit_idx=0, and the pending load is dropped.
- With SEG_LEADING_ZERO_BLANK_EN and digits 0x05 → digit1 is dark (anode enabled, seg=1111111) and digit0 = 0010010. Without the macro, digit1 = 1000000.
